// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: byte-to-bit serializer for the PHY link, clk_32f domain.
// Sends SYNC_COUNT COMMA bytes after reset, then data or IDLE_SYM, MSB first.
// Ports: clk_32f, reset (sync, active-high), data_in[7:0], valid_in,
//   [resync when PS_TX_RESYNC_EN is defined], data_out, data_ack, active.
// Optional macro PS_TX_RESYNC_EN adds a resync input to re-run the preamble.
module paralelo_serial_tx #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter logic [7:0]  IDLE_SYM   = 8'h7C
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
`ifdef PS_TX_RESYNC_EN
  input  logic       resync,
`endif
  output logic       data_out,
  output logic       data_ack,
  output logic       active
);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [3:0] LAST = 4'(SYNC_COUNT - 1);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [7:0] sym_q;
  logic [7:0] sym_d;
  logic [3:0] sync_cnt_q;
  logic       dout_q;
  logic       ack_q;
  logic       active_q;
  logic       load;
  logic       resync_hit;

  always_comb begin
    load = (cnt_q == 3'd0);
`ifdef PS_TX_RESYNC_EN
    resync_hit = (state_q == ACTIVE) && resync;
`else
    resync_hit = 1'b0;
`endif
    sym_d = IDLE_SYM;
    if (state_q == SYNC || resync_hit)
      sym_d = COMMA;
    else if (valid_in)
      sym_d = data_in;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SYNC;
      cnt_q      <= 3'd0;
      sym_q      <= 8'd0;
      sync_cnt_q <= 4'd0;
      dout_q     <= 1'b0;
      ack_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 3'd1;
      ack_q <= 1'b0;
      if (load) begin
        sym_q  <= sym_d;
        dout_q <= sym_d[7];
        unique case (state_q)
          SYNC: begin
            if (sync_cnt_q == LAST) begin
              sync_cnt_q <= 4'd0;
              state_q    <= ACTIVE;
              active_q   <= 1'b1;
            end else begin
              sync_cnt_q <= sync_cnt_q + 4'd1;
            end
          end
          ACTIVE: begin
            if (resync_hit) begin
              // This slot is comma #1, so the count restarts at 1.
              if (SYNC_COUNT > 1) begin
                state_q    <= SYNC;
                sync_cnt_q <= 4'd1;
                active_q   <= 1'b0;
              end
            end else begin
              ack_q <= valid_in;
            end
          end
          default: state_q <= SYNC;
        endcase
      end else begin
        // 7 - cnt for a 3-bit count is its bitwise inverse.
        dout_q <= sym_q[~cnt_q];
      end
    end
  end

  assign data_out = dout_q;
  assign data_ack = ack_q;
  assign active   = active_q;

endmodule
